// File: rtl/commit_stage.sv
// commit_stage: in-order retirement stage fed by the execute stage.
// Takes up to two results per cycle into a circular commit queue. Retires up to
// two results per cycle to the register-file write ports. Drives the store-commit
// handshake to the AGU and raises a one-cycle pipeline flush on exceptions and
// branch mispredicts.
//
// Optional feature: define COMMIT_TRACE_EN to add the debug_wb_* trace outputs.
// The trace is taken from retire slot 0, and a one-entry buffer holds the
// slot-1 trace for the following cycle.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   execute_to_commit_bus1/2     older/younger execute results
//   cs_allowin                   queue can accept two results this cycle
//   commit_store_valid/ready     store-commit handshake with the AGU
//   rf_we, rf_waddr0/1, rf_wdata0/1  register-file writes (port 0 is older)
//   flush, flush_pc              pipeline flush and redirect PC
//   debug_wb_*                   retire trace (COMMIT_TRACE_EN only)

package commit_stage_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        is_store;
    logic        exception;
    logic        mispredict;
    logic [31:0] target;
  } execute_to_commit_bus_t;

  // A queue entry keeps only the fields that retirement consumes.
  typedef struct packed {
`ifdef COMMIT_TRACE_EN
    logic [31:0] pc;
`endif
    logic        wen;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        is_store;
    logic        exception;
    logic        mispredict;
    logic [31:0] target;
  } commit_entry_t;

endpackage

module commit_stage
  import commit_stage_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  execute_to_commit_bus_t execute_to_commit_bus1,
  input  execute_to_commit_bus_t execute_to_commit_bus2,
  output logic                   cs_allowin,
  output logic                   commit_store_valid,
  input  logic                   commit_store_ready,
  output logic [1:0]             rf_we,
  output logic [4:0]             rf_waddr0,
  output logic [4:0]             rf_waddr1,
  output logic [31:0]            rf_wdata0,
  output logic [31:0]            rf_wdata1,
  output logic                   flush,
  output logic [31:0]            flush_pc
`ifdef COMMIT_TRACE_EN
  ,
  output logic [31:0]            debug_wb_pc,
  output logic [3:0]             debug_wb_rf_wen,
  output logic [4:0]             debug_wb_rf_wnum,
  output logic [31:0]            debug_wb_rf_wdata
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  commit_entry_t q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  commit_entry_t in1;
  commit_entry_t in2;
  commit_entry_t e0;
  commit_entry_t e1;
  logic          en1;
  logic          en2;
  logic [1:0]    n_enq;
  logic [1:0]    n_ret;
  logic          ret0;
  logic          ret1;
  logic          flush0;
  logic          flush1;
  logic          slot1_hold;

  // Strip the bus down to the stored entry fields.
  always_comb begin
    in1            = '0;
    in2            = '0;
`ifdef COMMIT_TRACE_EN
    in1.pc         = execute_to_commit_bus1.pc;
    in2.pc         = execute_to_commit_bus2.pc;
`endif
    in1.wen        = execute_to_commit_bus1.wen;
    in1.dest       = execute_to_commit_bus1.dest;
    in1.result     = execute_to_commit_bus1.result;
    in1.is_store   = execute_to_commit_bus1.is_store;
    in1.exception  = execute_to_commit_bus1.exception;
    in1.mispredict = execute_to_commit_bus1.mispredict;
    in1.target     = execute_to_commit_bus1.target;
    in2.wen        = execute_to_commit_bus2.wen;
    in2.dest       = execute_to_commit_bus2.dest;
    in2.result     = execute_to_commit_bus2.result;
    in2.is_store   = execute_to_commit_bus2.is_store;
    in2.exception  = execute_to_commit_bus2.exception;
    in2.mispredict = execute_to_commit_bus2.mispredict;
    in2.target     = execute_to_commit_bus2.target;
  end

  // Retire decision for the head (slot 0) and head+1 (slot 1).
  always_comb begin
    e0                 = q[head];
    e1                 = q[head + AW'(1)];
    ret0               = 1'b0;
    ret1               = 1'b0;
    flush0             = 1'b0;
    flush1             = 1'b0;
    commit_store_valid = 1'b0;
    rf_we              = 2'b00;
    rf_waddr0          = '0;
    rf_waddr1          = '0;
    rf_wdata0          = '0;
    rf_wdata1          = '0;
    flush_pc           = '0;

    if (count != '0) begin
      if (e0.exception) begin
        ret0     = 1'b1;
        flush0   = 1'b1;
        flush_pc = EXC_VECTOR;
      end else if (e0.is_store) begin
        // Store holds the head until the AGU takes it.
        commit_store_valid = 1'b1;
        ret0               = commit_store_ready;
      end else begin
        ret0 = 1'b1;
        if (e0.wen && (e0.dest != '0)) begin
          rf_we[0]  = 1'b1;
          rf_waddr0 = e0.dest;
          rf_wdata0 = e0.result;
        end
        if (e0.mispredict) begin
          flush0   = 1'b1;
          flush_pc = e0.target;
        end
      end
    end

    if (ret0 && !flush0 && (count >= CW'(2)) && !e1.is_store && !e1.exception && !slot1_hold) begin
      ret1 = 1'b1;
      if (e1.wen && (e1.dest != '0)) begin
        rf_we[1]  = 1'b1;
        rf_waddr1 = e1.dest;
        rf_wdata1 = e1.result;
      end
      if (e1.mispredict) begin
        flush1   = 1'b1;
        flush_pc = e1.target;
      end
    end

    flush      = flush0 | flush1;
    // Registered count only; a same-cycle retire does not open the queue.
    cs_allowin = (count <= CW'(DEPTH - 2)) && !flush;
    en1        = cs_allowin && execute_to_commit_bus1.valid;
    en2        = cs_allowin && execute_to_commit_bus2.valid;
    n_enq      = {1'b0, en1} + {1'b0, en2};
    n_ret      = {1'b0, ret0} + {1'b0, ret1};
  end

  // Queue storage; bus2 lands right after bus1, or at tail when alone.
  always_ff @(posedge clk) begin
    if (en1) q[tail] <= in1;
    if (en2) q[tail + AW'(en1)] <= in2;
  end

  // Pointers and occupancy; a flush empties the queue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_ret);
      tail  <= tail + AW'(n_enq);
      count <= count + CW'(n_enq) - CW'(n_ret);
    end
  end

`ifdef COMMIT_TRACE_EN
  logic        tb_valid;
  logic [31:0] tb_pc;
  logic [3:0]  tb_wen;
  logic [4:0]  tb_wnum;
  logic [31:0] tb_wdata;

  // While the buffer holds a slot-1 trace, only single retire is allowed.
  assign slot1_hold = tb_valid;

  // Trace output: buffered slot-1 entry first, otherwise the live slot 0.
  always_comb begin
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (tb_valid) begin
      debug_wb_pc       = tb_pc;
      debug_wb_rf_wen   = tb_wen;
      debug_wb_rf_wnum  = tb_wnum;
      debug_wb_rf_wdata = tb_wdata;
    end else if (ret0 && !e0.exception) begin
      debug_wb_pc       = e0.pc;
      debug_wb_rf_wen   = {4{rf_we[0]}};
      debug_wb_rf_wnum  = rf_waddr0;
      debug_wb_rf_wdata = rf_wdata0;
    end
  end

  // A buffered trace shifts slot 0 into the buffer, keeping program order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tb_valid <= 1'b0;
      tb_pc    <= '0;
      tb_wen   <= '0;
      tb_wnum  <= '0;
      tb_wdata <= '0;
    end else if (tb_valid) begin
      tb_valid <= ret0 && !e0.exception;
      tb_pc    <= e0.pc;
      tb_wen   <= {4{rf_we[0]}};
      tb_wnum  <= rf_waddr0;
      tb_wdata <= rf_wdata0;
    end else begin
      tb_valid <= ret1;
      tb_pc    <= e1.pc;
      tb_wen   <= {4{rf_we[1]}};
      tb_wnum  <= rf_waddr1;
      tb_wdata <= rf_wdata1;
    end
  end
`else
  assign slot1_hold = 1'b0;

  logic unused_pc;
  assign unused_pc = ^{execute_to_commit_bus1.pc, execute_to_commit_bus2.pc};
`endif

endmodule

// File: tb/tb_commit_stage.sv
// Self-checking bench for commit_stage: directed scenarios with literal
// expectations, then randomized traffic checked against a queue-based model.
module tb_commit_stage;
  import commit_stage_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] EXC   = 32'hBFC0_0380;

  logic                   clk = 1'b0;
  logic                   resetn = 1'b0;
  execute_to_commit_bus_t bus1;
  execute_to_commit_bus_t bus2;
  logic                   store_ready;
  logic                   cs_allowin;
  logic                   commit_store_valid;
  logic [1:0]             rf_we;
  logic [4:0]             rf_waddr0;
  logic [4:0]             rf_waddr1;
  logic [31:0]            rf_wdata0;
  logic [31:0]            rf_wdata1;
  logic                   flush;
  logic [31:0]            flush_pc;

  int total = 0;
  int bad   = 0;

  commit_stage #(.DEPTH(DEPTH), .EXC_VECTOR(EXC)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .execute_to_commit_bus1 (bus1),
    .execute_to_commit_bus2 (bus2),
    .cs_allowin             (cs_allowin),
    .commit_store_valid     (commit_store_valid),
    .commit_store_ready     (store_ready),
    .rf_we                  (rf_we),
    .rf_waddr0              (rf_waddr0),
    .rf_waddr1              (rf_waddr1),
    .rf_wdata0              (rf_wdata0),
    .rf_wdata1              (rf_wdata1),
    .flush                  (flush),
    .flush_pc               (flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        allowin;
    logic        sv;
    logic        flush;
    logic [31:0] fpc;
    logic [1:0]  we;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    int          nret;
  } exp_t;

  execute_to_commit_bus_t mq[$];
  exp_t cur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the oldest two queued results and the AGU ready.
  function automatic exp_t model(input bit rdy);
    exp_t e;
    execute_to_commit_bus_t h;
    execute_to_commit_bus_t y;
    e = '{allowin: 1'b0, sv: 1'b0, flush: 1'b0, fpc: 32'h0, we: 2'b00,
          a0: 5'h0, a1: 5'h0, d0: 32'h0, d1: 32'h0, nret: 0};
    if (mq.size() > 0) begin
      h = mq[0];
      if (h.exception) begin
        e.nret = 1; e.flush = 1'b1; e.fpc = EXC;
      end else if (h.is_store) begin
        e.sv = 1'b1;
        if (rdy) e.nret = 1;
      end else begin
        e.nret = 1;
        if (h.wen && h.dest != 0) begin e.we[0] = 1'b1; e.a0 = h.dest; e.d0 = h.result; end
        if (h.mispredict) begin e.flush = 1'b1; e.fpc = h.target; end
      end
      if (e.nret == 1 && !e.flush && mq.size() >= 2) begin
        y = mq[1];
        if (!y.is_store && !y.exception) begin
          e.nret = 2;
          if (y.wen && y.dest != 0) begin e.we[1] = 1'b1; e.a1 = y.dest; e.d1 = y.result; end
          if (y.mispredict) begin e.flush = 1'b1; e.fpc = y.target; end
        end
      end
    end
    e.allowin = (mq.size() <= DEPTH - 2) && !e.flush;
    return e;
  endfunction

  task automatic drive_check(input execute_to_commit_bus_t b1, input execute_to_commit_bus_t b2, input bit rdy);
    @(negedge clk);
    bus1 = b1;
    bus2 = b2;
    store_ready = rdy;
    #1;
    cur = model(rdy);
    chk("allowin", cs_allowin, cur.allowin);
    chk("store_valid", commit_store_valid, cur.sv);
    chk("flush", flush, cur.flush);
    chk("flush_pc", flush_pc, cur.fpc);
    chk("rf_we", rf_we, cur.we);
    chk("waddr0", rf_waddr0, cur.a0);
    chk("waddr1", rf_waddr1, cur.a1);
    chk("wdata0", rf_wdata0, cur.d0);
    chk("wdata1", rf_wdata1, cur.d1);
  endtask

  task automatic advance();
    if (cur.flush) mq.delete();
    else begin
      repeat (cur.nret) void'(mq.pop_front());
      if (cur.allowin) begin
        if (bus1.valid) mq.push_back(bus1);
        if (bus2.valid) mq.push_back(bus2);
      end
    end
    @(posedge clk);
  endtask

  function automatic execute_to_commit_bus_t alu(input logic [4:0] d, input logic [31:0] v);
    execute_to_commit_bus_t b;
    b = '0;
    b.valid = 1'b1; b.wen = 1'b1; b.dest = d; b.result = v; b.pc = 32'h8000_0000 + 32'(d);
    return b;
  endfunction

  function automatic execute_to_commit_bus_t rnd_bus();
    execute_to_commit_bus_t b;
    int k;
    k = int'($urandom_range(0, 9));
    b = '0;
    b.valid      = ($urandom_range(0, 3) != 0);
    b.pc         = $urandom;
    b.wen        = ($urandom_range(0, 3) != 0);
    b.dest       = 5'($urandom_range(0, 31));
    b.result     = $urandom;
    b.is_store   = (k == 6 || k == 7);
    b.exception  = (k == 8);
    b.mispredict = (k == 9);
    b.target     = $urandom;
    return b;
  endfunction

  execute_to_commit_bus_t idle;
  execute_to_commit_bus_t st;
  execute_to_commit_bus_t exc_e;
  execute_to_commit_bus_t mp;

  initial begin
    idle = '0;
    bus1 = '0;
    bus2 = '0;
    store_ready = 1'b0;
    st = '0; st.valid = 1'b1; st.is_store = 1'b1;
    exc_e = alu(5'd2, 32'hDEAD); exc_e.exception = 1'b1;
    mp = alu(5'd8, 32'h88); mp.mispredict = 1'b1; mp.target = 32'h8000_1000;

    // Reset values
    #3;
    chk("rst_allowin", cs_allowin, 1'b1);
    chk("rst_we", rf_we, 2'b00);
    chk("rst_flush", flush, 1'b0);
    chk("rst_sv", commit_store_valid, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // Dual ALU retire
    drive_check(alu(5'd3, 32'h11), alu(5'd4, 32'h22), 1'b0); advance();
    drive_check(idle, idle, 1'b0);
    chk("dual_we", rf_we, 2'b11);
    chk("dual_a0", rf_waddr0, 5'd3);
    chk("dual_d0", rf_wdata0, 32'h11);
    chk("dual_a1", rf_waddr1, 5'd4);
    chk("dual_d1", rf_wdata1, 32'h22);
    advance();
    drive_check(idle, idle, 1'b0);
    chk("dual_empty_we", rf_we, 2'b00);
    advance();

    // Store stalled three cycles, accepted on the fourth
    drive_check(st, idle, 1'b0); advance();
    for (int i = 0; i < 3; i++) begin
      drive_check(idle, idle, 1'b0);
      chk("st_wait_sv", commit_store_valid, 1'b1);
      chk("st_wait_we", rf_we, 2'b00);
      advance();
    end
    drive_check(alu(5'd5, 32'h55), idle, 1'b1);
    chk("st_go_sv", commit_store_valid, 1'b1);
    chk("st_go_we", rf_we, 2'b00);
    advance();
    drive_check(idle, idle, 1'b0);
    chk("st_after_sv", commit_store_valid, 1'b0);
    chk("st_after_we", rf_we, 2'b01);
    chk("st_after_d0", rf_wdata0, 32'h55);
    advance();

    // Head exception squashes the younger entry
    drive_check(exc_e, alu(5'd6, 32'h66), 1'b0); advance();
    drive_check(idle, idle, 1'b0);
    chk("exc_flush", flush, 1'b1);
    chk("exc_pc", flush_pc, 32'hBFC0_0380);
    chk("exc_we", rf_we, 2'b00);
    advance();
    drive_check(idle, idle, 1'b0);
    chk("exc_after_we", rf_we, 2'b00);
    chk("exc_after_flush", flush, 1'b0);
    advance();

    // Slot-1 mispredict; same-cycle input discarded
    drive_check(alu(5'd7, 32'h77), mp, 1'b0); advance();
    drive_check(alu(5'd9, 32'h99), idle, 1'b0);
    chk("mp_we", rf_we, 2'b11);
    chk("mp_a1", rf_waddr1, 5'd8);
    chk("mp_flush", flush, 1'b1);
    chk("mp_pc", flush_pc, 32'h8000_1000);
    chk("mp_allowin", cs_allowin, 1'b0);
    advance();
    drive_check(idle, idle, 1'b0);
    chk("mp_after_we", rf_we, 2'b00);
    advance();

    // Fill to DEPTH-1 behind a stalled store, then reset mid-stall
    drive_check(st, alu(5'd10, 32'hA), 1'b0); advance();
    drive_check(alu(5'd11, 32'hB), idle, 1'b0); advance();
    for (int i = 0; i < 3; i++) begin
      drive_check(alu(5'd12, 32'hC), alu(5'd13, 32'hD), 1'b0);
      chk("full_allowin", cs_allowin, 1'b0);
      chk("full_sv", commit_store_valid, 1'b1);
      advance();
    end
    drive_check(idle, idle, 1'b0);
    #1 resetn = 1'b0;
    #1;
    chk("arst_allowin", cs_allowin, 1'b1);
    chk("arst_sv", commit_store_valid, 1'b0);
    chk("arst_we", rf_we, 2'b00);
    chk("arst_a0", rf_waddr0, 5'd0);
    chk("arst_d0", rf_wdata0, 32'h0);
    chk("arst_a1", rf_waddr1, 5'd0);
    chk("arst_d1", rf_wdata1, 32'h0);
    chk("arst_flush", flush, 1'b0);
    chk("arst_pc", flush_pc, 32'h0);
    mq.delete();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      drive_check(rnd_bus(), rnd_bus(), 1'($urandom_range(0, 1)));
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commit_stage.md
# commit_stage

In-order retirement stage directly downstream of the execute stage. It accepts up to two `execute_to_commit_bus_t` results per cycle into a small circular commit queue and retires up to two per cycle to the register-file write ports. It also drives the store-commit handshake back to the AGU and raises the pipeline `flush` on exceptions and branch mispredicts. Slot 1 is always older than slot 2.

## Interface
- `DEPTH`, 4: commit-queue entries; power of two, ≥ 4.
- `EXC_VECTOR`, 32'hBFC0_0380: `flush_pc` on exception.
- `clk` in 1: clock, all state on posedge.
- `resetn` in 1: reset, asynchronous, active-low.
- `execute_to_commit_bus1` in `execute_to_commit_bus_t`: older result. Fields used: `valid`, `pc[31:0]`, `wen`, `dest[4:0]`, `result[31:0]`, `is_store`, `exception`, `mispredict`, `target[31:0]`.
- `execute_to_commit_bus2` in `execute_to_commit_bus_t`: younger result, same fields.
- `cs_allowin` out 1: queue can take two results this cycle.
- `commit_store_valid` out 1: head store may write memory.
- `commit_store_ready` in 1: AGU accepted the store this cycle.
- `rf_we` out 2: per-port register write enable.
- `rf_waddr0`, `rf_waddr1` out 5: write addresses; port 0 is older.
- `rf_wdata0`, `rf_wdata1` out 32: write data.
- `flush` out 1: one-cycle pipeline flush.
- `flush_pc` out 32: redirect PC; 0 when `flush` = 0.

## Operation
- The queue is a circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- Enqueue at posedge when `cs_allowin` is 1:
  - bus1.valid enqueues at tail and bus2.valid enqueues after it.
  - If only bus2 is valid, it takes a single slot at tail.
  - Inputs arriving while `cs_allowin` is 0 are ignored. The execute stage holds them.
- `cs_allowin` = (count ≤ DEPTH−2) && !flush. It uses the registered count only; a retire in the same cycle does not bypass into it.
- Retire slot 0 (head), combinational from the head entry:
  - exception: no register write, no store; `flush`=1, `flush_pc`=EXC_VECTOR; entry is consumed.
  - store, no exception: `commit_store_valid`=1. The entry retires only in a cycle with `commit_store_ready`=1; otherwise it holds and nothing retires.
  - other: retires, and `rf_we[0]` = wen && dest≠0.
  - mispredict (no exception): retires with its register write; `flush`=1, `flush_pc`=target.
- Retire slot 1 (head+1) requires all of:
  - count ≥ 2 and slot 0 retires;
  - slot 0 raises no flush;
  - slot 1 is not a store and carries no exception.
  - A mispredict in slot 1 retires with its write and raises `flush`/`flush_pc`=target.
- Only one `commit_store_valid` per cycle; stores always retire from slot 0.
- Flush: at the posedge ending a `flush`=1 cycle, head=tail=count=0. Enqueue in that same cycle is suppressed by `cs_allowin`=0.

## Timing
- Latency: a result enqueued at posedge N is presented on `rf_*` in cycle N+1 if it reaches the head. Minimum is 1 cycle.
- `flush` is combinational from the head entry and lasts exactly one cycle per flushing entry.
- Store handshake: `commit_store_valid` stays high until the cycle `commit_store_ready` is high. That cycle retires the store and the store is never re-presented.
- Simultaneous enqueue and retire: count_next = count + enq − ret (enq, ret ∈ 0..2).
- Reset (any time, including mid-store): queue empties. Outputs are `cs_allowin`=1, `commit_store_valid`=0, `rf_we`=0, `rf_waddr*`/`rf_wdata*`=0, `flush`=0, `flush_pc`=0.
- Full: count=DEPTH−1 or DEPTH gives `cs_allowin`=0. Empty: all retire outputs are 0.

## Configuration
- `COMMIT_TRACE_EN` defined: adds outputs `debug_wb_pc` (32), `debug_wb_rf_wen` (4), `debug_wb_rf_wnum` (5) and `debug_wb_rf_wdata` (32), traced from retire slot 0.
  - When slot 1 also retires, its trace is emitted the following cycle from a one-entry trace buffer.
  - While that buffer is occupied, slot-1 retire is suppressed.
- `COMMIT_TRACE_EN` undefined: no debug ports, no trace buffer, dual retire unrestricted.

## Test plan
- Empty queue; bus1 ALU (dest 3, 0x11), bus2 ALU (dest 4, 0x22) → next cycle `rf_we`=2'b11, waddr0=3/wdata0=0x11, waddr1=4/wdata1=0x22; count returns to 0.
- Head store, `commit_store_ready` low 3 cycles then high → `commit_store_valid` high 4 cycles, no `rf_we`, store retires on cycle 4, younger ALU retires next cycle.
- Head exception with younger ALU entry → `flush`=1, `flush_pc`=0xBFC00380, `rf_we`=0; queue empty next cycle, younger entry never writes.
- Mispredict in slot 1 with target 0x80001000, slot 0 plain ALU → both write, `flush_pc`=0x80001000; bus input in same cycle discarded.
- Fill to DEPTH−1 with stalled store → `cs_allowin`=0, new inputs ignored; `resetn` pulled low mid-stall → all outputs 0 asynchronously, `cs_allowin`=1 after release.
